fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch front end for the Riscv151 pipeline. It owns the fetch PC, issues requests to the synchronous icache, and buffers up to DEPTH fetched {pc, instruction} pairs. Decode consumes them through a valid/ready handshake. It replaces the single PC register plus one-entry PC delay with a decoupled queue that supports zero-bubble redirects, flushing, and the global memory stall.

---
 rtl/fetch_queue_unit_pkg.sv | 12 +
 rtl/fetch_queue_unit_if.sv | 33 +++
 rtl/fetch_queue_unit_fetch_fifo.sv | 56 +++++
 rtl/fetch_queue_unit.sv | 91 +++++++++
 tb/tb_fetch_queue_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// Shared constants for the instruction-fetch front end: reset PC, canonical NOP,
// and the occupancy-counter width helper (wide enough to represent a full queue).
package fetch_queue_unit_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_2000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch-unit bus: icache request/response, redirect input and the decode-side
// valid/ready head port. master = fetch unit, slave = icache/decode environment.
interface fetch_queue_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 3
);
    logic [XLEN-1:0]  icache_addr;
    logic             icache_re;
    logic [XLEN-1:0]  icache_dout;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_instr;
    logic [CNT_W-1:0] occupancy;

    modport master (
        output icache_addr, icache_re,
        input  icache_dout,
        input  redirect_valid, redirect_pc,
        output out_valid, out_pc, out_instr, occupancy,
        input  out_ready
    );

    modport slave (
        input  icache_addr, icache_re,
        output icache_dout,
        output redirect_valid, redirect_pc,
        input  out_valid, out_pc, out_instr, occupancy,
        output out_ready
    );
endinterface

// File: rtl/fetch_queue_unit_fetch_fifo.sv
// Circular {pc, instr} buffer: push/pop/flush with count; head read is from registers.
// Flush beats push and still advances head on a concurrent pop; the parent gates all enables.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           head_dat_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        head_d  = head_q + PW'(pop_i);
        tail_d  = tail_q + PW'(push_i);
        count_d = count_q + CW'(push_i) - CW'(pop_i);
        if (flush_i) begin
            tail_d  = head_d;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[tail_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[head_q];
    assign count_o    = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch PC owner + DEPTH-entry decoupling queue; issue->head 2 cycles, 1 instr/cycle steady state.
// Credit-based issue (queued + in-flight never exceeds DEPTH); stall freezes all state.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(PC_RESET)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    fetch_queue_unit_if.master bus
);
    localparam int               CNT_W   = cnt_width(DEPTH);
    localparam int               ENT_W   = 2 * XLEN;
    localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic             inflight_vld_q, inflight_vld_d;
    logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0] count;
    logic [ENT_W-1:0] head_dat;
    logic [XLEN-1:0]  target;
    logic [CNT_W:0]   pending;
    logic             out_vld;
    logic             redirect, pop, push, credit, issue;

    assign out_vld  = (count != '0);
    assign redirect = bus.redirect_valid & ~stall;
    assign pop      = out_vld & bus.out_ready & ~stall;
    assign push     = inflight_vld_q & ~stall & ~reset & ~bus.redirect_valid;
    assign target   = bus.redirect_pc & ~XLEN'(3);

    // Entries already promised to the queue once this cycle's pop retires.
    assign pending  = {1'b0, count} + (CNT_W + 1)'(inflight_vld_q) - (CNT_W + 1)'(pop);
    assign credit   = (pending < DEPTH_W);
    // A redirect flushes the queue, so its target never waits for credit.
    assign issue    = ~stall & ~reset & (redirect | credit);

    assign bus.icache_re   = issue;
    assign bus.icache_addr = (issue & redirect) ? target : fetch_pc_q;

    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        inflight_vld_d = inflight_vld_q;
        inflight_pc_d  = inflight_pc_q;
        if (issue) begin
            fetch_pc_d = bus.icache_addr + XLEN'(4);
        end
        if (!stall) begin
            inflight_vld_d = issue;
            if (issue) begin
                inflight_pc_d = bus.icache_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q     <= RESET_PC;
            inflight_vld_q <= 1'b0;
            inflight_pc_q  <= RESET_PC;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            inflight_vld_q <= inflight_vld_d;
            inflight_pc_q  <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i ({inflight_pc_q, bus.icache_dout}),
        .pop_i      (pop & ~reset),
        .flush_i    (redirect & ~reset),
        .head_dat_o (head_dat),
        .count_o    (count)
    );

    assign bus.out_valid = out_vld;
    assign bus.out_pc    = head_dat[ENT_W-1:XLEN];
    assign bus.out_instr = out_vld ? head_dat[XLEN-1:0] : XLEN'(INSTR_NOP);
    assign bus.occupancy = count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed scenarios then randomized traffic, checked against a queue-based model
// of the fetch front end's externally visible behaviour.
module tb_fetch_queue_unit;

    localparam int          DEPTH = 4;
    localparam int          XLEN  = 32;
    localparam logic [31:0] RST_PC = 32'h0000_2000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic clk;
    logic reset;
    logic stall;

    fetch_queue_unit_if #(.XLEN(XLEN), .CNT_W(3)) bus ();

    fetch_queue_unit #(
        .DEPTH    (DEPTH),
        .XLEN     (XLEN),
        .RESET_PC (RST_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .bus   (bus)
    );

    int n_tests;
    int n_fail;

    // Model state
    logic [31:0] m_pc;
    bit          m_inf_v;
    logic [31:0] m_inf_pc;
    ent_t        m_q[$];

    // Expectations for the cycle being driven
    bit          e_pop, e_redir, e_issue, e_rst, e_stall;
    logic [31:0] e_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous icache: data for the last non-stalled address, held while stalled.
    always @(posedge clk) begin
        if (!stall) begin
            bus.icache_dout <= mem_word(bus.icache_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input bit rv, input logic [31:0] rpc,
                         input bit rdy, input bit rst, input bit do_chk);
        stall              = s;
        reset              = rst;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        #1;
        e_rst   = rst;
        e_stall = s;
        e_pop   = (m_q.size() > 0) && rdy && !s;
        e_redir = rv && !s;
        e_issue = !s && !rst &&
                  (e_redir || (m_q.size() + int'(m_inf_v) - int'(e_pop) < DEPTH));
        e_addr  = (e_issue && e_redir) ? {rpc[31:2], 2'b00} : m_pc;
        if (do_chk) begin
            chk("icache_re",   32'(bus.icache_re), 32'(e_issue));
            chk("icache_addr", bus.icache_addr, e_addr);
            chk("out_valid",   32'(bus.out_valid), 32'(m_q.size() > 0));
            chk("occupancy",   32'(bus.occupancy), 32'(m_q.size()));
            if (m_q.size() > 0) begin
                chk("out_pc",    bus.out_pc, m_q[0].pc);
                chk("out_instr", bus.out_instr, m_q[0].ins);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (e_rst) begin
            m_q.delete();
            m_inf_v = 1'b0;
            m_pc    = RST_PC;
        end else if (!e_stall) begin
            if (e_pop) void'(m_q.pop_front());
            if (e_redir) m_q.delete();
            else if (m_inf_v) m_q.push_back('{pc: m_inf_pc, ins: mem_word(m_inf_pc)});
            m_inf_v  = e_issue;
            m_inf_pc = e_addr;
            if (e_issue) m_pc = e_addr + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic cyc(input bit s, input bit rv, input logic [31:0] rpc,
                       input bit rdy, input bit rst);
        drive(s, rv, rpc, rdy, rst, 1'b1);
        tick();
    endtask

    int          n_re;
    int          q_snap;
    logic [31:0] pc_snap;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        stall = 1'b0; reset = 1'b1;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
        m_pc = RST_PC; m_inf_v = 1'b0; m_inf_pc = '0;

        // Reset and stream
        drive(0, 0, 0, 1, 1, 0); tick();
        drive(0, 0, 0, 1, 1, 1);
        chk("rst_re",  32'(bus.icache_re), 0);
        chk("rst_vld", 32'(bus.out_valid), 0);
        chk("rst_occ", 32'(bus.occupancy), 0);
        tick();
        drive(0, 0, 0, 1, 0, 1); chk("st_addr0", bus.icache_addr, 32'h2000); tick();
        drive(0, 0, 0, 1, 0, 1); chk("st_addr1", bus.icache_addr, 32'h2004);
        chk("st_vld1", 32'(bus.out_valid), 0); tick();
        drive(0, 0, 0, 1, 0, 1); chk("st_vld2", 32'(bus.out_valid), 1);
        chk("st_pc2", bus.out_pc, 32'h2000); tick();
        repeat (6) cyc(0, 0, 0, 1, 0);

        // Backpressure: exactly DEPTH requests, then ordered drain
        cyc(0, 0, 0, 0, 1);
        n_re = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 1); n_re += int'(bus.icache_re); tick();
        end
        chk("bp_issued", 32'(n_re), 32'd4);
        drive(0, 0, 0, 0, 0, 1);
        chk("bp_occ", 32'(bus.occupancy), 32'd4);
        chk("bp_re",  32'(bus.icache_re), 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 0, 1); chk("bp_order", bus.out_pc, 32'h2000 + 32'(4 * i)); tick();
        end

        // Redirect with entries queued and one in flight
        cyc(0, 0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 0);
        drive(0, 1, 32'h3003, 0, 0, 1);
        chk("rd_addr", bus.icache_addr, 32'h3000);
        chk("rd_re",   32'(bus.icache_re), 1); tick();
        drive(0, 0, 0, 1, 0, 1); chk("rd_occ", 32'(bus.occupancy), 0); tick();
        drive(0, 0, 0, 1, 0, 1); chk("rd_head", bus.out_pc, 32'h3000); tick();

        // Stall with a redirect present: everything frozen, redirect ignored
        repeat (3) cyc(0, 0, 0, 1, 0);
        q_snap  = m_q.size();
        pc_snap = m_pc;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'h5000, 1, 0, 1);
            chk("sl_re",   32'(bus.icache_re), 0);
            chk("sl_addr", bus.icache_addr, pc_snap);
            chk("sl_occ",  32'(bus.occupancy), 32'(q_snap));
            tick();
        end
        repeat (6) cyc(0, 0, 0, 1, 0);

        // Full queue, pop and redirect in the same cycle
        cyc(0, 0, 0, 0, 1);
        repeat (6) cyc(0, 0, 0, 0, 0);
        drive(0, 1, 32'h4000, 1, 0, 1);
        chk("fr_addr", bus.icache_addr, 32'h4000);
        chk("fr_re",   32'(bus.icache_re), 1);
        chk("fr_pop",  bus.out_pc, 32'h2000); tick();
        drive(0, 0, 0, 1, 0, 1); chk("fr_occ", 32'(bus.occupancy), 0); tick();
        drive(0, 0, 0, 1, 0, 1); chk("fr_head", bus.out_pc, 32'h4000); tick();

        // Reset mid-run with three queued entries and stall high
        cyc(0, 0, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 0, 0);
        chk("mr_pre", 32'(m_q.size()), 32'd3);
        cyc(1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("mr_vld",  32'(bus.out_valid), 0);
        chk("mr_occ",  32'(bus.occupancy), 0);
        chk("mr_addr", bus.icache_addr, 32'h2000); tick();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 99) < 20,
                $urandom_range(0, 99) < 8,
                ($urandom & 32'h0000_FFFF) | 32'h0001_0000,
                $urandom_range(0, 99) < 70,
                $urandom_range(0, 99) < 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
